// File: rtl/cnn_pkg.sv
// Shared CNN definitions: layer-4 result geometry and the result-reader state encoding.
package cnn_pkg;

    localparam int L4_LANES  = 16;
    localparam int L4_GROUPS = 4;
    localparam int L4_DW     = 18;

    typedef enum logic [2:0] {
        IDLE,
        CAP,
        SEND,
        DONE,
        CLR
    } rd_state_t;

endpackage

// File: rtl/l4_result_reader_if.sv
// Valid/ready result stream from the layer-4 reader to the next stage.
interface l4_result_reader_if
    import cnn_pkg::*;
#(
    parameter int DW = L4_DW
);

    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;

    modport master (output out_data, output out_valid, output out_last, input out_ready);
    modport slave  (input out_data, input out_valid, input out_last, output out_ready);

endinterface

// File: rtl/l4_result_reader.sv
// Captures 64 layer-4 results (4 groups x 16 lanes) on a rising rdy and streams them
// one word per cycle, then pulses tx_done so layer 4 can clear for the next image.
module l4_result_reader
    import cnn_pkg::*;
#(
    parameter int LANES  = L4_LANES,
    parameter int GROUPS = L4_GROUPS,
    parameter int DW     = L4_DW
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rdy,
    input  logic [LANES-1:0][DW-1:0]  din,
    l4_result_reader_if.master        out_if,
    output logic                      tx_done,
    output logic                      busy
);

    localparam int WORDS  = LANES * GROUPS;
    localparam int IDX_W  = $clog2(WORDS);
    localparam int GRP_W  = $clog2(GROUPS);
    localparam int LANE_W = $clog2(LANES);

    rd_state_t        state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [GRP_W-1:0] grp_q, grp_d;
    logic             wait_q, wait_d;
    logic             rdy_q;
    logic             start;
    logic             hs;
    logic             cap_en;
    logic [DW-1:0]    mem_q [WORDS];

    assign start = rdy & ~rdy_q;
    assign hs    = out_if.out_valid & out_if.out_ready;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_d = state_q;
        idx_d   = idx_q;
        grp_d   = grp_q;
        wait_d  = wait_q;
        cap_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CAP;
                    grp_d   = '0;
                    wait_d  = 1'b1;
                end
            end
            CAP: begin
                if (!rdy) begin
                    state_d = IDLE;
                end else if (wait_q) begin
                    wait_d = 1'b0;   // RAM read latency: first group arrives next cycle
                end else begin
                    cap_en = 1'b1;
                    grp_d  = grp_q + GRP_W'(1);
                    if (grp_q == GRP_W'(GROUPS - 1)) begin
                        state_d = SEND;
                        idx_d   = '0;
                    end
                end
            end
            SEND: begin
                if (!rdy) begin
                    state_d = IDLE;
                end else if (hs) begin
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(WORDS - 1)) state_d = DONE;
                end
            end
            DONE: state_d = CLR;
            CLR: begin
                if (!rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state and counters use non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            grp_q   <= '0;
            wait_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            grp_q   <= grp_d;
            wait_q  <= wait_d;
            rdy_q   <= rdy;
        end
    end

    // NOTE: the result buffer has no reset; it is always fully rewritten before SEND reads it.
    always_ff @(posedge clk) begin
        if (cap_en) begin
            for (int n = 0; n < LANES; n++) begin
                mem_q[{grp_q, LANE_W'(n)}] <= din[n];
            end
        end
    end

    assign out_if.out_valid = (state_q == SEND);
    assign out_if.out_data  = out_if.out_valid ? mem_q[idx_q] : '0;
    assign out_if.out_last  = out_if.out_valid && (idx_q == IDX_W'(WORDS - 1));
    assign tx_done          = (state_q == DONE);
    assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_l4_result_reader.sv
// Directed bench for l4_result_reader: a lane model feeds din, a stream collector checks order and handshake.
module tb_l4_result_reader;

    logic                 clk;
    logic                 rst_n;
    logic                 rdy;
    logic [15:0][17:0]    din;
    logic                 tx_done;
    logic                 busy;
    int                   checks;
    int                   errors;
    int                   ph;
    int                   lane_mode;

    l4_result_reader_if #(.DW(18)) bus ();

    l4_result_reader dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rdy     (rdy),
        .din     (din),
        .out_if  (bus),
        .tx_done (tx_done),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [17:0] model_word(input int mode, input int k);
        if (mode == 0) return 18'(k + 1);
        if (mode == 1) return 18'h3FFFF;
        return 18'h00000;
    endfunction

    // Layer-4 model: group g is presented in the (g+2)th cycle after rdy is first sampled high.
    always @(posedge clk) begin
        ph = rdy ? ph + 1 : 0;
        #1;
        for (int n = 0; n < 16; n++) begin
            din[n] = (ph >= 2 && ph <= 5) ? model_word(lane_mode, (ph - 2) * 16 + n) : 18'h15555;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Raises rdy (caller sits just after a negedge) and collects one full 64-word stream.
    task automatic run_stream(input int mode, input bit stall, input bit drop_rdy);
        int            k;
        int            lat;
        int            first_lat;
        int            stalls;
        bit            held_v;
        bit            early_done;
        logic [17:0]   held;
        lane_mode = mode;
        check("idle_before_start", 32'(busy), 0);
        rdy = 1'b1;
        k = 0; lat = 0; first_lat = -1; stalls = 0; held_v = 1'b0; early_done = 1'b0; held = '0;
        while (k < 64 && lat < 400) begin
            @(negedge clk);
            lat++;
            bus.out_ready = stall ? ((lat - 1) % 3 == 0) : 1'b1;
            if (tx_done) early_done = 1'b1;
            if (bus.out_valid) begin
                if (first_lat < 0) first_lat = lat;
                if (held_v) check("stall_data_stable", 32'(bus.out_data), 32'(held));
                if (bus.out_ready) begin
                    check("word_data", 32'(bus.out_data), 32'(model_word(mode, k)));
                    check("word_last", 32'(bus.out_last), (k == 63) ? 1 : 0);
                    k++;
                    held_v = 1'b0;
                end else begin
                    held   = bus.out_data;
                    held_v = 1'b1;
                    stalls++;
                end
            end
        end
        check("handshake_count", k, 64);
        check("first_valid_latency", first_lat, 6);
        check("no_early_tx_done", 32'(early_done), 0);
        if (stall) check("stalls_exercised", (stalls > 0) ? 1 : 0, 1);
        @(negedge clk);
        check("tx_done_pulse", 32'(tx_done), 1);
        check("valid_low_in_done", 32'(bus.out_valid), 0);
        if (drop_rdy) rdy = 1'b0;
        @(negedge clk);
        check("tx_done_one_cycle", 32'(tx_done), 0);
        check("busy_in_clr", 32'(busy), 1);
        if (drop_rdy) begin
            @(negedge clk);
            check("idle_after_rdy_low", 32'(busy), 0);
        end
    endtask

    initial begin
        int  k;
        int  lat;
        bit  seen_done;
        checks = 0; errors = 0; ph = 0; lane_mode = 0;
        rst_n = 1'b0; rdy = 1'b0; bus.out_ready = 1'b0; din = '0;
        #1;
        check("reset_out_valid", 32'(bus.out_valid), 0);
        check("reset_out_last", 32'(bus.out_last), 0);
        check("reset_out_data", 32'(bus.out_data), 0);
        check("reset_tx_done", 32'(tx_done), 0);
        check("reset_busy", 32'(busy), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: plain stream, always ready
        run_stream(0, 1'b0, 1'b1);

        // 2: downstream stalls with ready pattern 1,0,0
        run_stream(0, 1'b1, 1'b1);
        bus.out_ready = 1'b1;

        // 3: rdy held high after tx_done must not restart the block
        run_stream(0, 1'b0, 1'b0);
        seen_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid || !busy) seen_done = 1'b1;
        end
        check("held_rdy_stays_in_clr", 32'(seen_done), 0);
        rdy = 1'b0;
        @(negedge clk);
        check("clr_exit_on_rdy_low", 32'(busy), 0);
        run_stream(0, 1'b0, 1'b1);

        // 4: rdy dropped mid-stream at idx=10
        lane_mode = 0; rdy = 1'b1; bus.out_ready = 1'b1; k = 0; lat = 0;
        while (k < 10 && lat < 100) begin
            @(negedge clk);
            lat++;
            if (bus.out_valid && bus.out_ready) k++;
        end
        check("abort_prefix_count", k, 10);
        @(negedge clk);
        check("abort_word10", 32'(bus.out_data), 11);
        rdy = 1'b0; bus.out_ready = 1'b0;
        @(negedge clk);
        check("abort_valid_low", 32'(bus.out_valid), 0);
        check("abort_idle", 32'(busy), 0);
        seen_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (tx_done) seen_done = 1'b1;
        end
        check("abort_no_tx_done", 32'(seen_done), 0);
        run_stream(0, 1'b0, 1'b1);

        // 5: asynchronous reset in the middle of capture
        lane_mode = 0; rdy = 1'b1;
        repeat (3) @(negedge clk);
        check("busy_in_cap", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(bus.out_valid), 0);
        check("async_rst_busy", 32'(busy), 0);
        check("async_rst_data", 32'(bus.out_data), 0);
        rdy = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_stream(0, 1'b0, 1'b1);

        // 6: back-to-back images, all-ones then all-zeros
        run_stream(1, 1'b0, 1'b1);
        run_stream(2, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
